alu_serial_4: RTL and testbench

Bit-serial counterpart of the team's parallel 4-bit ripple ALU. Accepts a full operand pair and op code through a valid/ready handshake, then evaluates one bit per clock, LSB first. A single 1-bit slice and a registered carry replace the rippled carry chain. Results are returned through a second valid/ready handshake, so the block sits between a sequencer or test driver and any consumer that tolerates multi-cycle latency.

---
 rtl/alu_serial_4.sv | 143 ++++++++++++++
 tb/tb_alu_serial_4.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_4.sv
// alu_serial_4: bit-serial 4-bit ALU (AND/OR/XOR/ADD), LSB first.
// One 1-bit slice plus a registered carry stands in for the ripple chain.
// The operand bundle is taken through one valid/ready handshake and the
// result is returned through a second one.
module alu_serial_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       c,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [1:0]       op_q,    op_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             cout_q,  cout_d;

  logic abit, bbit, rbit, cnext, last_bit;

  // 1-bit slice: result bit and next carry for the bit selected by the counter.
  always_comb begin
    abit  = a_q[cnt_q];
    bbit  = b_q[cnt_q];
    rbit  = 1'b0;
    cnext = 1'b0;
    case (op_q)
      OP_AND: rbit = abit & bbit;
      OP_OR:  rbit = abit | bbit;
      OP_XOR: rbit = abit ^ bbit;
      OP_ADD: begin
        rbit  = abit ^ bbit ^ carry_q;
        cnext = (abit & bbit) | (abit & carry_q) | (bbit & carry_q);
      end
      default: ;
    endcase
  end

  assign last_bit = (cnt_q == CW'(WIDTH-1));

  // Next-state logic: handshakes, bit sequencing and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    out_d   = out_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = c;
          // Carry-in only matters for ADD; logic ops always run with carry 0.
          carry_d = (c == OP_ADD) ? cin : 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // New bit enters at the MSB so bit 0 lands in out[0] after WIDTH shifts.
        res_d   = {rbit, res_q[WIDTH-1:1]};
        carry_d = cnext;
        if (last_bit) begin
          cnt_d   = '0;
          out_d   = {rbit, res_q[WIDTH-1:1]};
          cout_d  = cnext;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake flags are pure decodes of the registered state.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out       = out_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_alu_serial_4.sv
// tb_alu_serial_4: directed plus random stimulus, checked every cycle against
// a latency/arithmetic reference model, with literal pins on known cases.
module tb_alu_serial_4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   c = '0;
  logic         in_ready, out_valid, cout, busy;
  logic [W-1:0] out;

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_serial_4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .cout(cout), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference result: plain arithmetic, {cout, out}.
  function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [1:0] op, input logic ci);
    case (op)
      2'b00:   return {1'b0, x & y};
      2'b01:   return {1'b0, x | y};
      2'b10:   return {1'b0, x ^ y};
      default: return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endcase
  endfunction

  // Model: m_t = edges since acceptance (0 idle, 1..W computing, W+1 result held).
  int           m_t = 0;
  logic [W-1:0] m_out = '0;
  logic         m_cout = 1'b0;
  logic [W:0]   m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_out <= '0; m_cout <= 1'b0; m_pend <= '0;
    end else if (m_t == 0) begin
      if (in_valid) begin
        m_t <= 1;
        m_pend <= ref_op(a, b, c, cin);
      end
    end else if (m_t <= W) begin
      m_t <= m_t + 1;
      if (m_t == W) {m_cout, m_out} <= m_pend;
    end else if (out_ready) begin
      m_t <= 0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Completed result handshakes, for spacing/ordering checks.
  logic [W:0] hs_q[$];
  int         hs_t[$];
  always @(posedge clk)
    if (rst_n && out_valid && out_ready) begin
      hs_q.push_back({cout, out});
      hs_t.push_back(cyc);
    end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk)
    if (cmp_en) begin
      chk("in_ready", in_ready, m_t == 0);
      chk("out_valid", out_valid, m_t == W + 1);
      chk("busy", busy, m_t != 0);
      chk("out", out, m_out);
      chk("cout", cout, m_cout);
    end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a bundle and wait for it to be accepted; optionally keep in_valid high.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [1:0] tc,
                      input logic tcin, input bit hold);
    bit ok;
    ok = 1'b0;
    a = ta; b = tb_; c = tc; cin = tcin; in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = in_ready;
      tick();
    end
    if (!ok) chk("send_timeout", 0, 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  logic [W-1:0] lexp [3] = '{4'b1000, 4'b1110, 4'b0110};

  initial begin
    int lat;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", out, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // ADD with carry-in: 1011 + 0110 + 1 = 1_0010.
    out_ready = 1'b1;
    send(4'b1011, 4'b0110, 2'b11, 1'b1, 1'b0);
    wait_valid(lat);
    chk("add_latency", lat, W);
    chk("add_out", out, 4'b0010);
    chk("add_cout", cout, 1);
    tick();
    chk("add_ready_back", in_ready, 1);

    // Logic ops ignore cin.
    for (int op = 0; op < 3; op++) begin
      send(4'b1100, 4'b1010, 2'(op), 1'b1, 1'b0);
      wait_valid(lat);
      chk("logic_out", out, lexp[op]);
      chk("logic_cout", cout, 0);
      tick();
    end

    // Backpressure: 1111 + 0001 held in DONE while in_valid pulses.
    out_ready = 1'b0;
    send(4'b1111, 4'b0001, 2'b11, 1'b0, 1'b0);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      a = W'($urandom);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_out", out, 4'b0000);
      chk("bp_cout", cout, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    chk("done_exit_no_accept", busy, 0);
    chk("out_held_idle", {cout, out}, 5'b1_0000);
    in_valid = 1'b0;
    tick();

    // Back-to-back with in_valid held.
    hs_q.delete();
    hs_t.delete();
    send(4'b0011, 4'b0101, 2'b11, 1'b0, 1'b1);
    send(4'b1111, 4'b0000, 2'b10, 1'b0, 1'b0);
    repeat (12) tick();
    chk("b2b_count", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      chk("b2b_first", hs_q[0], 5'b0_1000);
      chk("b2b_second", hs_q[1], 5'b0_1111);
      chk("b2b_spacing", hs_t[1] - hs_t[0], W + 2);
    end

    // Reset on the second RUN cycle, then a fresh op.
    send(4'b1010, 4'b0101, 2'b11, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", {cout, out}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(4'b0111, 4'b0001, 2'b11, 1'b0, 1'b0);
    wait_valid(lat);
    chk("post_rst_latency", lat, W);
    chk("post_rst_out", {cout, out}, 5'b0_1000);
    tick();

    // Random traffic with random backpressure and occasional resets.
    for (int k = 0; k < 2000; k++) begin
      in_valid  = 1'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      c         = 2'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
